aud_seq_ctrl: RTL and testbench

Top-level record/playback sequencer for the audio lab datapath. Turns debounced key pulses into one-cycle start/pause/stop commands for the recorder and the playback DSP, and tracks the recorded length. Owns the single SRAM port and muxes it between the recorder write stream and the DSP read address. Sits between the key debouncers and the recorder, DSP and SRAM pins in the top module.

---
 rtl/aud_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_aud_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_seq_ctrl.sv
// Record/playback sequencer: turns key pulses into one-cycle recorder/DSP commands,
// tracks the recorded length and muxes the single SRAM port between record and playback.
module aud_seq_ctrl #(
  parameter int                ADDR_W   = 20,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_record,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_rec_valid,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  input  logic [ADDR_W-1:0] i_play_addr,
  input  logic              i_play_done,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic [ADDR_W:0]   o_rec_len,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REC        = 3'd1,
    REC_PAUSE  = 3'd2,
    PLAY       = 3'd3,
    PLAY_PAUSE = 3'd4
  } state_t;

  localparam int CMD_REC_START = 5;
  localparam int CMD_REC_PAUSE = 4;
  localparam int CMD_REC_STOP  = 3;
  localparam int CMD_DSP_START = 2;
  localparam int CMD_DSP_PAUSE = 1;
  localparam int CMD_DSP_STOP  = 0;

  state_t          state, state_nxt;
  logic [5:0]      cmd, cmd_nxt;
  logic [ADDR_W:0] rec_len, len_nxt;
  logic            rec_wr;
  logic            rec_full;

  assign rec_wr   = (state == REC) && i_rec_valid;
  assign rec_full = rec_wr && (i_rec_addr == MAX_ADDR);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cmd     <= '0;
      rec_len <= '0;
    end else begin
      state   <= state_nxt;
      cmd     <= cmd_nxt;
      rec_len <= len_nxt;
    end
  end

  // Each branch tests keys in stop > pause > record > play order, skipping keys
  // that have no meaning in that state, so the first legal key wins.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = '0;
    len_nxt   = rec_len;
    case (state)
      IDLE: begin
        if (i_key_record) begin
          state_nxt              = REC;
          cmd_nxt[CMD_REC_START] = 1'b1;
          len_nxt                = '0;
        end else if (i_key_play && (rec_len != '0)) begin
          state_nxt              = PLAY;
          cmd_nxt[CMD_DSP_START] = 1'b1;
        end
      end
      REC: begin
        if (rec_wr) begin
          len_nxt = {1'b0, i_rec_addr} + {{ADDR_W{1'b0}}, 1'b1};
        end
        // A full memory overrides pause, so the last word always ends the take.
        if (i_key_stop || rec_full) begin
          state_nxt             = IDLE;
          cmd_nxt[CMD_REC_STOP] = 1'b1;
        end else if (i_key_pause) begin
          state_nxt              = REC_PAUSE;
          cmd_nxt[CMD_REC_PAUSE] = 1'b1;
        end
      end
      REC_PAUSE: begin
        if (i_key_stop) begin
          state_nxt             = IDLE;
          cmd_nxt[CMD_REC_STOP] = 1'b1;
        end else if (i_key_record) begin
          state_nxt              = REC;
          cmd_nxt[CMD_REC_START] = 1'b1;
        end
      end
      PLAY: begin
        if (i_key_stop || i_play_done) begin
          state_nxt             = IDLE;
          cmd_nxt[CMD_DSP_STOP] = 1'b1;
        end else if (i_key_pause) begin
          state_nxt              = PLAY_PAUSE;
          cmd_nxt[CMD_DSP_PAUSE] = 1'b1;
        end
      end
      PLAY_PAUSE: begin
        if (i_key_stop) begin
          state_nxt             = IDLE;
          cmd_nxt[CMD_DSP_STOP] = 1'b1;
        end else if (i_key_play) begin
          state_nxt              = PLAY;
          cmd_nxt[CMD_DSP_START] = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM port is purely combinational so the write strobe lines up with i_rec_valid.
  always_comb begin
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    o_sram_we_n  = 1'b1;
    o_sram_oe_n  = 1'b1;
    case (state)
      REC, REC_PAUSE: begin
        o_sram_addr  = i_rec_addr;
        o_sram_wdata = i_rec_data;
        o_sram_we_n  = ~rec_wr;
      end
      PLAY, PLAY_PAUSE: begin
        o_sram_addr = i_play_addr;
        o_sram_oe_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_rec_start = cmd[CMD_REC_START];
  assign o_rec_pause = cmd[CMD_REC_PAUSE];
  assign o_rec_stop  = cmd[CMD_REC_STOP];
  assign o_dsp_start = cmd[CMD_DSP_START];
  assign o_dsp_pause = cmd[CMD_DSP_PAUSE];
  assign o_dsp_stop  = cmd[CMD_DSP_STOP];
  assign o_rec_len   = rec_len;
  assign o_state     = state;

endmodule

// File: tb/tb_aud_seq_ctrl.sv
// Bench for aud_seq_ctrl: table-driven key/state model checked every cycle, plus
// directed sequences with literal expectations.
module tb_aud_seq_ctrl;

  localparam logic [19:0] MAXA = 20'h7;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_key_record = 1'b0, i_key_play = 1'b0, i_key_pause = 1'b0, i_key_stop = 1'b0;
  logic        i_rec_valid = 1'b0;
  logic [19:0] i_rec_addr = '0;
  logic [15:0] i_rec_data = '0;
  logic [19:0] i_play_addr = '0;
  logic        i_play_done = 1'b0;
  logic        o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_wdata;
  logic        o_sram_we_n, o_sram_oe_n;
  logic [20:0] o_rec_len;
  logic [2:0]  o_state;

  aud_seq_ctrl #(.MAX_ADDR(MAXA)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_key_record(i_key_record), .i_key_play(i_key_play),
    .i_key_pause(i_key_pause), .i_key_stop(i_key_stop),
    .i_rec_valid(i_rec_valid), .i_rec_addr(i_rec_addr), .i_rec_data(i_rec_data),
    .i_play_addr(i_play_addr), .i_play_done(i_play_done),
    .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause), .o_rec_stop(o_rec_stop),
    .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause), .o_dsp_stop(o_dsp_stop),
    .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata),
    .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n),
    .o_rec_len(o_rec_len), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse vector order: {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop}
  localparam logic [5:0] RS = 6'b100000, RP = 6'b010000, RX = 6'b001000;
  localparam logic [5:0] DS = 6'b000100, DP = 6'b000010, DX = 6'b000001;

  // Key index 0..3 = stop, pause, record, play (priority order); dest -1 = key illegal.
  int         dest [5][4];
  logic [5:0] puls [5][4];
  initial begin
    dest[0] = '{-1, -1, 1, 3};  puls[0] = '{0, 0, RS, DS};
    dest[1] = '{ 0,  2, -1, -1}; puls[1] = '{RX, RP, 0, 0};
    dest[2] = '{ 0, -1, 1, -1};  puls[2] = '{RX, 0, RS, 0};
    dest[3] = '{ 0,  4, -1, -1}; puls[3] = '{DX, DP, 0, 0};
    dest[4] = '{ 0, -1, -1, 3};  puls[4] = '{DX, 0, 0, DS};
  end

  int         m_state = 0;
  int         m_len   = 0;
  logic [5:0] m_pulse = '0;
  bit         m_live  = 1'b0;

  always @(posedge i_clk) begin
    bit p[4];
    bit done;
    int ns, nlen;
    logic [5:0] np;
    if (!i_rst_n) begin
      m_state = 0; m_len = 0; m_pulse = '0; m_live = 1'b1;
    end else begin
      p[0] = i_key_stop; p[1] = i_key_pause; p[2] = i_key_record; p[3] = i_key_play;
      ns = m_state; np = '0; nlen = m_len; done = 1'b0;
      if (m_state == 1 && i_rec_valid) begin
        nlen = int'(i_rec_addr) + 1;
        if (i_rec_addr == MAXA) p[0] = 1'b1;
      end
      if (m_state == 3 && i_play_done) p[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (!done && p[k] && dest[m_state][k] >= 0 && !(m_state == 0 && k == 3 && m_len == 0)) begin
          ns = dest[m_state][k];
          np = puls[m_state][k];
          if (m_state == 0 && k == 2) nlen = 0;
          done = 1'b1;
        end
      end
      m_state = ns; m_pulse = np; m_len = nlen;
    end
  end

  always @(negedge i_clk) begin
    logic [19:0] ea; logic [15:0] ed; logic ew, eo;
    if (m_live) begin
      ea = '0; ed = '0; ew = 1'b1; eo = 1'b1;
      if (m_state == 1 || m_state == 2) begin
        ea = i_rec_addr; ed = i_rec_data; ew = !(i_rec_valid && m_state == 1);
      end else if (m_state == 3 || m_state == 4) begin
        ea = i_play_addr; eo = 1'b0;
      end
      check("model_state", 32'(o_state), 32'(m_state));
      check("model_pulses", 32'({o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop}), 32'(m_pulse));
      check("model_len", 32'(o_rec_len), 32'(m_len));
      check("model_sram", {o_sram_addr[13:0], o_sram_wdata, o_sram_we_n, o_sram_oe_n},
            {ea[13:0], ed, ew, eo});
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic keys(input bit rec, input bit play, input bit pause, input bit stop);
    i_key_record = rec; i_key_play = play; i_key_pause = pause; i_key_stop = stop;
  endtask

  logic [15:0] wdat [3];
  logic [5:0]  pv;

  initial begin
    wdat[0] = 16'hAAAA; wdat[1] = 16'hF0F0; wdat[2] = 16'h0F0F;
    tick(); tick();
    check("rst_state", 32'(o_state), 0);
    check("rst_len", 32'(o_rec_len), 0);
    check("rst_sram", {o_sram_addr[15:0], o_sram_we_n, o_sram_oe_n}, {16'h0, 1'b1, 1'b1});
    i_rst_n = 1'b1;
    tick();

    keys(1, 0, 0, 0); tick(); keys(0, 0, 0, 0);
    check("rec_state", 32'(o_state), 1);
    check("rec_start", 32'(o_rec_start), 1);
    check("rec_len0", 32'(o_rec_len), 0);
    tick();
    check("rec_start_once", 32'(o_rec_start), 0);

    for (int i = 0; i < 3; i++) begin
      i_rec_valid = 1'b1; i_rec_addr = 20'(i); i_rec_data = wdat[i];
      #1;
      check("wr_we", 32'(o_sram_we_n), 0);
      check("wr_addr_data", {o_sram_addr[15:0], o_sram_wdata}, {16'(i), wdat[i]});
      tick();
      i_rec_valid = 1'b0;
      #1;
      check("wr_idle_we", 32'(o_sram_we_n), 1);
    end
    check("len3", 32'(o_rec_len), 3);

    keys(0, 0, 1, 0); tick(); keys(0, 0, 0, 0);
    check("pause_state", 32'(o_state), 2);
    check("rec_pause", 32'(o_rec_pause), 1);
    i_rec_valid = 1'b1; i_rec_addr = 20'h5; i_rec_data = 16'h1234;
    #1;
    check("stray_we", 32'(o_sram_we_n), 1);
    tick(); i_rec_valid = 1'b0;
    check("stray_len", 32'(o_rec_len), 3);

    keys(1, 0, 1, 0); tick(); keys(0, 0, 0, 0);
    check("resume_state", 32'(o_state), 1);
    check("resume_len", 32'(o_rec_len), 3);
    keys(0, 0, 0, 1); tick(); keys(0, 0, 0, 0);
    check("stop_state", 32'(o_state), 0);
    check("rec_stop", 32'(o_rec_stop), 1);
    check("stop_len", 32'(o_rec_len), 3);

    keys(0, 0, 1, 1); tick(); keys(0, 0, 0, 0);
    check("idle_ignore", {29'(o_state), 3'(o_rec_pause + o_rec_stop)}, 0);

    i_play_addr = 20'h2;
    keys(0, 1, 0, 0); tick(); keys(0, 0, 0, 0);
    check("play_state", 32'(o_state), 3);
    check("dsp_start", 32'(o_dsp_start), 1);
    check("play_sram", {o_sram_addr[15:0], o_sram_we_n, o_sram_oe_n}, {16'h2, 1'b1, 1'b0});
    i_play_addr = 20'h1; #1;
    check("play_addr_follow", 32'(o_sram_addr), 1);
    keys(0, 0, 1, 0); tick(); keys(0, 0, 0, 0);
    check("ppause_state", 32'(o_state), 4);
    i_play_done = 1'b1; tick(); i_play_done = 1'b0;
    check("ppause_done_ignored", 32'(o_state), 4);
    keys(0, 1, 0, 0); tick(); keys(0, 0, 0, 0);
    check("replay_state", 32'(o_state), 3);
    i_play_done = 1'b1; tick(); i_play_done = 1'b0;
    check("done_state", 32'(o_state), 0);
    check("dsp_stop", 32'(o_dsp_stop), 1);

    i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
    keys(0, 1, 0, 0); tick(); keys(0, 0, 0, 0);
    pv = {o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop};
    check("play_len0_state", 32'(o_state), 0);
    check("play_len0_pulse", 32'(pv), 0);

    keys(1, 1, 0, 1); tick(); keys(0, 0, 0, 0);
    pv = {o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop};
    check("prio_state", 32'(o_state), 1);
    check("prio_pulse", 32'(pv), 32'(RS));

    i_rec_valid = 1'b1; i_rec_addr = MAXA; i_rec_data = 16'hBEEF;
    #1;
    check("full_we", 32'(o_sram_we_n), 0);
    tick(); i_rec_valid = 1'b0;
    check("full_state", 32'(o_state), 0);
    check("full_stop", 32'(o_rec_stop), 1);
    check("full_len", 32'(o_rec_len), 8);
    tick();
    check("full_stop_once", 32'(o_rec_stop), 0);

    keys(1, 0, 0, 0); tick(); keys(0, 0, 0, 0);
    check("rerec_len", 32'(o_rec_len), 0);
    i_rec_valid = 1'b1; i_rec_addr = MAXA; keys(0, 0, 1, 0);
    tick(); i_rec_valid = 1'b0; keys(0, 0, 0, 0);
    pv = {o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop};
    check("full_pause_state", 32'(o_state), 0);
    check("full_pause_pulse", 32'(pv), 32'(RX));
    check("full_pause_len", 32'(o_rec_len), 8);

    keys(1, 0, 0, 0); tick(); keys(0, 0, 0, 0);
    i_rec_valid = 1'b1; i_rec_addr = 20'h3; keys(0, 0, 0, 1);
    tick(); i_rec_valid = 1'b0; keys(0, 0, 0, 0);
    check("wr_stop_state", 32'(o_state), 0);
    check("wr_stop_len", 32'(o_rec_len), 4);

    i_play_addr = 20'h3;
    keys(0, 1, 0, 0); tick(); keys(0, 0, 0, 0);
    check("play2_state", 32'(o_state), 3);
    tick();
    i_rst_n = 1'b0; tick();
    pv = {o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop};
    check("midplay_rst_state", 32'(o_state), 0);
    check("midplay_rst_pulse", 32'(pv), 0);
    check("midplay_rst_len", 32'(o_rec_len), 0);
    check("midplay_rst_sram", {o_sram_addr[15:0], o_sram_wdata, o_sram_we_n, o_sram_oe_n},
          {16'h0, 16'h0, 1'b1, 1'b1});
    i_rst_n = 1'b1; tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
